// File: rtl/mxv_uart_pkg.sv
// Shared definitions for the UART result-frame control units (transmit and receive side).
// Holds the frame state encoding and the fixed framing bytes.
package mxv_uart_pkg;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    HDR      = 4'd1,
    HDRWAIT  = 4'd2,
    LEN      = 4'd3,
    LENWAIT  = 4'd4,
    FETCH    = 4'd5,
    DATA     = 4'd6,
    DATAWAIT = 4'd7,
    TRL      = 4'd8,
    TRLWAIT  = 4'd9,
    DONE     = 4'd10
  } tx_state_t;

  localparam logic [7:0] HDR_BYTE = 8'hFE;
  localparam logic [7:0] TRL_BYTE = 8'hEF;

  // States that hand a byte to the UART transmitter.
  function automatic logic is_tx_state(input tx_state_t s);
    return (s == HDR) || (s == LEN) || (s == DATA) || (s == TRL);
  endfunction

endpackage

// File: rtl/tx_idx_counter.sv
// Data-byte index for the transmit frame: cleared when a frame is accepted, stepped per byte,
// and held at len_q-1 so it never wraps past the last byte.
module tx_idx_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [3:0] len_q,
  output logic [3:0] count,
  output logic       terminal
);

  // len_q-1 wraps to 15 when len_q is 0; the FSM never consults terminal in that case.
  assign terminal = (count == (len_q - 4'd1));

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !terminal) begin
      count <= count + 4'd1;
    end
  end

endmodule

// File: rtl/ctl_unit_txfield.sv
// Transmit-side control unit: sends one result frame FE, {0,LENGTH}, buffer[0..LENGTH-1], EF
// through a byte-wide UART transmitter, one TXSTART/TXDONE handshake per byte.
module ctl_unit_txfield
  import mxv_uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       START,
  input  logic [3:0] LENGTH,
  input  logic       TXDONE,
  input  logic [7:0] RDDATA,
  output logic       TXSTART,
  output logic [7:0] TXDATA,
  output logic [3:0] RDADDR,
  output logic       BUSY,
  output logic       DONEFLAG
);

  tx_state_t  state;
  logic [3:0] len_q;
  logic [3:0] idx;
  logic       idx_last;
  logic       idx_clear;
  logic       idx_step;

  assign idx_clear = (state == IDLE) && START;
  assign idx_step  = (state == DATAWAIT) && TXDONE;

  tx_idx_counter u_idx (
    .clk      (clk),
    .reset    (reset),
    .clear    (idx_clear),
    .enable   (idx_step),
    .len_q    (len_q),
    .count    (idx),
    .terminal (idx_last)
  );

  // TXDONE is only consulted in the *WAIT states, so a pulse overlapping a TXSTART cycle is ignored.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      len_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            len_q <= LENGTH;
            state <= HDR;
          end
        end
        HDR:      state <= HDRWAIT;
        HDRWAIT:  if (TXDONE) state <= LEN;
        LEN:      state <= LENWAIT;
        LENWAIT:  if (TXDONE) state <= (len_q == 4'd0) ? TRL : FETCH;
        FETCH:    state <= DATA;
        DATA:     state <= DATAWAIT;
        DATAWAIT: if (TXDONE) state <= idx_last ? TRL : FETCH;
        TRL:      state <= TRLWAIT;
        TRLWAIT:  if (TXDONE) state <= DONE;
        DONE:     state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

  // Outputs decode straight from the state register, so an async reset clears them at once.
  // NOTE: every always_comb output gets a default first, otherwise unlisted states infer latches.
  always_comb begin
    TXDATA = 8'h00;
    case (state)
      HDR:     TXDATA = HDR_BYTE;
      LEN:     TXDATA = {4'h0, len_q};
      DATA:    TXDATA = RDDATA;
      TRL:     TXDATA = TRL_BYTE;
      default: TXDATA = 8'h00;
    endcase
  end

  assign TXSTART  = is_tx_state(state);
  assign RDADDR   = idx;
  assign BUSY     = (state != IDLE);
  assign DONEFLAG = (state == DONE);

endmodule

// File: tb/tb_ctl_unit_txfield.sv
// Directed bench for ctl_unit_txfield: drives frames against a registered result-buffer model
// and checks byte order, handshakes, ignored inputs, mid-frame reset and length latching.
module tb_ctl_unit_txfield;

  logic       clk = 1'b0;
  logic       reset;
  logic       START;
  logic [3:0] LENGTH;
  logic       TXDONE;
  logic [7:0] RDDATA;
  logic       TXSTART;
  logic [7:0] TXDATA;
  logic [3:0] RDADDR;
  logic       BUSY;
  logic       DONEFLAG;

  logic [7:0] mem [16];
  int n_cmp = 0;
  int n_bad = 0;

  ctl_unit_txfield dut (
    .clk      (clk),
    .reset    (reset),
    .START    (START),
    .LENGTH   (LENGTH),
    .TXDONE   (TXDONE),
    .RDDATA   (RDDATA),
    .TXSTART  (TXSTART),
    .TXDATA   (TXDATA),
    .RDADDR   (RDADDR),
    .BUSY     (BUSY),
    .DONEFLAG (DONEFLAG)
  );

  always #5 clk = ~clk;

  // Result buffer: synchronous read, data valid one cycle after the address.
  always @(posedge clk) RDDATA <= mem[RDADDR];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_txstart"},  TXSTART,  32'd0);
    chk({tag, "_txdata"},   TXDATA,   32'h00);
    chk({tag, "_busy"},     BUSY,     32'd0);
    chk({tag, "_doneflag"}, DONEFLAG, 32'd0);
  endtask

  // Runs one whole frame, answering every TXSTART with a TXDONE 'gap' cycles later.
  // chg_len >= 0 rewrites LENGTH once the length byte has gone out (i.e. during LENWAIT).
  task automatic run_frame(input string tag, input int len, input int gap, input int chg_len);
    logic [7:0] got[$];
    logic [3:0] adr[$];
    logic [7:0] exp_b;
    int cnt, dones, done_cyc, end_cyc, nchk;
    bit ended;
    START  = 1'b1;
    LENGTH = len[3:0];
    tick();
    START = 1'b0;
    chk({tag, "_latency"}, TXSTART, 32'd1);
    chk({tag, "_first_byte"}, TXDATA, 32'hFE);
    cnt = -1; dones = 0; done_cyc = -1; end_cyc = -1; ended = 1'b0;
    for (int cyc = 0; cyc < 2000; cyc++) begin
      if (!BUSY) begin
        end_cyc = cyc;
        ended = 1'b1;
        break;
      end
      if (TXSTART) begin
        got.push_back(TXDATA);
        adr.push_back(RDADDR);
        cnt = 0;
        if (got.size() == 2 && chg_len >= 0) LENGTH = chg_len[3:0];
      end
      if (DONEFLAG) begin
        dones++;
        done_cyc = cyc;
      end
      TXDONE = (cnt == gap);
      if (cnt == gap) cnt = -1;
      else if (cnt >= 0) cnt++;
      tick();
    end
    TXDONE = 1'b0;
    chk({tag, "_frame_ends"}, ended, 32'd1);
    chk({tag, "_pulse_count"}, got.size(), len + 3);
    chk({tag, "_done_pulses"}, dones, 32'd1);
    chk({tag, "_busy_falls_after_done"}, end_cyc, done_cyc + 1);
    nchk = (got.size() < len + 3) ? got.size() : len + 3;
    for (int i = 0; i < nchk; i++) begin
      if (i == 0)            exp_b = 8'hFE;
      else if (i == 1)       exp_b = {4'h0, len[3:0]};
      else if (i == len + 2) exp_b = 8'hEF;
      else                   exp_b = mem[i-2];
      chk($sformatf("%s_byte%0d", tag, i), got[i], exp_b);
      if (i >= 2 && i < len + 2) chk($sformatf("%s_addr%0d", tag, i), adr[i], i - 2);
    end
    chk({tag, "_final_rdaddr"}, RDADDR, (len == 0) ? 0 : len - 1);
  endtask

  initial begin
    reset = 1'b0; START = 1'b0; LENGTH = 4'd0; TXDONE = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    tick();
    tick();
    chk_idle_outputs("reset");
    chk("reset_rdaddr", RDADDR, 32'd0);
    reset = 1'b1;
    tick();
    chk_idle_outputs("post_reset");

    // Basic two-byte frame.
    mem[0] = 8'h11; mem[1] = 8'h22;
    run_frame("len2", 2, 10, -1);

    // Empty frame: header, length, trailer only.
    run_frame("len0", 0, 10, -1);

    // Longest frame; index stops at 14.
    for (int i = 0; i < 16; i++) mem[i] = 8'hA0 + 8'(i);
    run_frame("len15", 15, 10, -1);

    // Ignored inputs: stray TXDONE in IDLE, START in HDRWAIT and DONE, TXDONE in FETCH/DATA.
    mem[0] = 8'h5A;
    TXDONE = 1'b1;
    tick();
    TXDONE = 1'b0;
    chk_idle_outputs("stray_txdone_idle");
    START = 1'b1; LENGTH = 4'd1;
    tick();                                 // HDR
    START = 1'b0;
    chk("ign_hdr_txstart", TXSTART, 32'd1);
    tick();                                 // HDRWAIT
    START = 1'b1;
    tick();                                 // still HDRWAIT
    START = 1'b0;
    chk("ign_start_hdrwait_txstart", TXSTART, 32'd0);
    chk("ign_start_hdrwait_busy", BUSY, 32'd1);
    TXDONE = 1'b1;
    tick();                                 // LEN
    TXDONE = 1'b0;
    chk("ign_len_byte", TXDATA, 32'h01);
    tick();                                 // LENWAIT
    TXDONE = 1'b1;
    tick();                                 // FETCH, TXDONE held high
    chk("ign_fetch_txstart", TXSTART, 32'd0);
    tick();                                 // DATA, TXDONE overlaps TXSTART
    chk("ign_data_txstart", TXSTART, 32'd1);
    chk("ign_data_byte", TXDATA, 32'h5A);
    TXDONE = 1'b0;
    tick();                                 // DATAWAIT (TXDONE in DATA did not skip it)
    tick();
    chk("ign_datawait_hold_txstart", TXSTART, 32'd0);
    chk("ign_datawait_hold_busy", BUSY, 32'd1);
    TXDONE = 1'b1;
    tick();                                 // TRL
    TXDONE = 1'b0;
    chk("ign_trl_byte", TXDATA, 32'hEF);
    tick();                                 // TRLWAIT
    TXDONE = 1'b1;
    tick();                                 // DONE
    TXDONE = 1'b0;
    chk("ign_done_flag", DONEFLAG, 32'd1);
    START = 1'b1; LENGTH = 4'd2;
    tick();                                 // IDLE; START in DONE dropped
    START = 1'b0;
    chk_idle_outputs("ign_start_done");
    tick();
    chk_idle_outputs("ign_start_done_next");

    // Reset in DATAWAIT of a LENGTH=5 frame (second data byte).
    START = 1'b1; LENGTH = 4'd5;
    tick();                                 // HDR
    START = 1'b0;
    tick();                                 // HDRWAIT
    TXDONE = 1'b1; tick(); TXDONE = 1'b0;   // LEN
    tick();                                 // LENWAIT
    TXDONE = 1'b1; tick(); TXDONE = 1'b0;   // FETCH idx0
    tick(); tick();                         // DATA, DATAWAIT
    TXDONE = 1'b1; tick(); TXDONE = 1'b0;   // FETCH idx1
    tick(); tick();                         // DATA, DATAWAIT
    chk("rst_pre_rdaddr", RDADDR, 32'd1);
    chk("rst_pre_busy", BUSY, 32'd1);
    reset = 1'b0;
    #1;
    chk_idle_outputs("rst_async");
    chk("rst_async_rdaddr", RDADDR, 32'd0);
    TXDONE = 1'b1;
    tick();
    TXDONE = 1'b0;
    chk("rst_held_txstart", TXSTART, 32'd0);
    reset = 1'b1;
    tick();
    tick();
    chk_idle_outputs("rst_released_waits");
    mem[0] = 8'h11; mem[1] = 8'h22;
    run_frame("after_rst", 2, 10, -1);

    // LENGTH changes 3 -> 7 while the frame is in LENWAIT.
    mem[0] = 8'h31; mem[1] = 8'h32; mem[2] = 8'h33;
    run_frame("len_change", 3, 10, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
